// File: rtl/mips_pkg.sv
// Shared encodings for the ID/EX operand path: immediate extension modes and
// register-operand forwarding sources.
package mips_pkg;

  typedef enum logic [1:0] {
    EXT_SIGN  = 2'b00,
    EXT_ZERO  = 2'b01,
    EXT_UPPER = 2'b10
  } ext_mode_e;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/imm_ext.sv
// Immediate extender: sign, zero or upper placement of an IW-bit field into DW
// bits. Purely combinational so the branch-target logic can share it.
module imm_ext
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int IW = 16
) (
  input  logic [IW-1:0] imm,
  input  logic [1:0]    ext_mode,
  output logic [DW-1:0] ext
);

  // NOTE: ext gets a full default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ext = {{(DW-IW){imm[IW-1]}}, imm};
    case (ext_mode)
      EXT_ZERO:  ext = {{(DW-IW){1'b0}}, imm};
      EXT_UPPER: ext = {imm, {(DW-IW){1'b0}}};
      default:   ;  // EXT_SIGN and the reserved code both sign-extend
    endcase
  end

endmodule

// File: rtl/srcb_stage.sv
// ID/EX source-B stage: forwards the register operand, extends the immediate,
// selects ALU source B and registers it with store data and a valid bit.
module srcb_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          stall,
  input  logic          flush,
  input  logic [DW-1:0] rd2,
  input  logic [DW-1:0] exmem_result,
  input  logic [DW-1:0] memwb_result,
  input  logic [1:0]    fwd_sel,
  input  logic [IW-1:0] imm,
  input  logic [1:0]    ext_mode,
  input  logic          alu_src,
  output logic          out_valid,
  output logic [DW-1:0] srcb,
  output logic [DW-1:0] store_data,
  output logic [DW-1:0] ext_imm
);

  logic [DW-1:0] op;
  logic [DW-1:0] ext;
  logic [DW-1:0] b;

  always_comb begin
    op = rd2;
    case (fwd_sel)
      FWD_EXMEM: op = exmem_result;
      FWD_MEMWB: op = memwb_result;
      default:   ;  // FWD_RF and the reserved code read the register file
    endcase
  end

  imm_ext #(.DW(DW), .IW(IW)) u_imm_ext (
    .imm      (imm),
    .ext_mode (ext_mode),
    .ext      (ext)
  );

  assign b = alu_src ? ext : op;

  // NOTE: non-blocking assignments keep every register sampling pre-edge
  // values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid  <= 1'b0;
      srcb       <= '0;
      store_data <= '0;
      ext_imm    <= '0;
    end else if (!stall) begin
      out_valid <= in_valid;
      if (in_valid) begin
        srcb       <= b;
        store_data <= op;
        ext_imm    <= ext;
      end else begin
        // Bubbles carry zero data so downstream never sees stale operands.
        srcb       <= '0;
        store_data <= '0;
        ext_imm    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_srcb_stage.sv
// Self-checking bench for srcb_stage at DW=32 and DW=64 sharing one stimulus
// stream, with a behavioural model plus directed literal expectations.
module tb_srcb_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush, alu_src;
  logic [63:0] rd2_w, exmem_w, memwb_w;
  logic [1:0]  fwd_sel, ext_mode;
  logic [15:0] imm;

  logic        valid32, valid64;
  logic [31:0] srcb32, store32, ext32;
  logic [63:0] srcb64, store64, ext64;

  int passed = 0;
  int total  = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  srcb_stage #(.DW(32), .IW(16)) dut32 (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .stall        (stall),
    .flush        (flush),
    .rd2          (rd2_w[31:0]),
    .exmem_result (exmem_w[31:0]),
    .memwb_result (memwb_w[31:0]),
    .fwd_sel      (fwd_sel),
    .imm          (imm),
    .ext_mode     (ext_mode),
    .alu_src      (alu_src),
    .out_valid    (valid32),
    .srcb         (srcb32),
    .store_data   (store32),
    .ext_imm      (ext32)
  );

  srcb_stage #(.DW(64), .IW(16)) dut64 (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .stall        (stall),
    .flush        (flush),
    .rd2          (rd2_w),
    .exmem_result (exmem_w),
    .memwb_result (memwb_w),
    .fwd_sel      (fwd_sel),
    .imm          (imm),
    .ext_mode     (ext_mode),
    .alu_src      (alu_src),
    .out_valid    (valid64),
    .srcb         (srcb64),
    .store_data   (store64),
    .ext_imm      (ext64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        valid;
    logic [63:0] srcb;
    logic [63:0] store;
    logic [63:0] ext;
  } out_t;

  out_t e32, e64;

  function automatic logic [63:0] width_mask(input int dw);
    return (dw == 64) ? {64{1'b1}} : ((64'd1 << dw) - 64'd1);
  endfunction

  function automatic logic [63:0] ext_model(input int dw);
    logic [63:0] r;
    logic signed [63:0] s;
    s = 64'(signed'(imm));
    case (ext_mode)
      2'b01:   r = 64'(imm);
      2'b10:   r = 64'(imm) << (dw - 16);
      default: r = s;
    endcase
    return r & width_mask(dw);
  endfunction

  function automatic out_t model_next(input out_t cur, input int dw);
    out_t n;
    logic [63:0] opv;
    n = cur;
    if (reset || flush) begin
      n = '{1'b0, 64'd0, 64'd0, 64'd0};
    end else if (!stall) begin
      case (fwd_sel)
        2'b01:   opv = exmem_w;
        2'b10:   opv = memwb_w;
        default: opv = rd2_w;
      endcase
      opv = opv & width_mask(dw);
      if (in_valid) begin
        n.valid = 1'b1;
        n.ext   = ext_model(dw);
        n.store = opv;
        n.srcb  = alu_src ? n.ext : opv;
      end else begin
        n = '{1'b0, 64'd0, 64'd0, 64'd0};
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    e32     <= model_next(e32, 32);
    e64     <= model_next(e64, 64);
    started <= 1'b1;
  end

  // Single compare process: outputs sampled mid-cycle against the model.
  always @(negedge clk) begin
    if (started) begin
      check("m_valid32", 64'(valid32), 64'(e32.valid));
      check("m_srcb32",  64'(srcb32),  e32.srcb);
      check("m_store32", 64'(store32), e32.store);
      check("m_ext32",   64'(ext32),   e32.ext);
      check("m_valid64", 64'(valid64), 64'(e64.valid));
      check("m_srcb64",  srcb64,       e64.srcb);
      check("m_store64", store64,      e64.store);
      check("m_ext64",   ext64,        e64.ext);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; alu_src = 1'b0;
    rd2_w = '0; exmem_w = '0; memwb_w = '0; fwd_sel = 2'b00; ext_mode = 2'b00;
    imm = '0;
    step(); step();
    check("rst_valid32", 64'(valid32), 64'd0);
    check("rst_srcb32",  64'(srcb32),  64'd0);
    check("rst_store64", store64,      64'd0);
    check("rst_ext64",   ext64,        64'd0);

    reset = 1'b0; in_valid = 1'b1; alu_src = 1'b1; imm = 16'h8001; ext_mode = 2'b00;
    step();
    check("sign_srcb32",  64'(srcb32),  64'hFFFF_8001);
    check("sign_valid32", 64'(valid32), 64'd1);
    check("sign_srcb64",  srcb64,       64'hFFFF_FFFF_FFFF_8001);
    ext_mode = 2'b01; step();
    check("zero_srcb32",  64'(srcb32),  64'h0000_8001);
    ext_mode = 2'b10; step();
    check("upper_srcb32", 64'(srcb32),  64'h8001_0000);
    check("upper_srcb64", srcb64,       64'h8001_0000_0000_0000);
    ext_mode = 2'b11; step();
    check("rsv_ext32",    64'(ext32),   64'hFFFF_8001);

    rd2_w = 64'd1; exmem_w = 64'd2; memwb_w = 64'd3; alu_src = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fwd_sel = 2'(i);
      step();
      check("fwd_srcb32",  64'(srcb32),  (i == 3) ? 64'd1 : 64'(i + 1));
      check("fwd_store32", 64'(store32), (i == 3) ? 64'd1 : 64'(i + 1));
    end

    alu_src = 1'b1; imm = 16'h0004; ext_mode = 2'b00; fwd_sel = 2'b01;
    exmem_w = 64'h0000_0000_DEAD_BEEF;
    step();
    check("st_srcb32",  64'(srcb32),  64'd4);
    check("st_store32", 64'(store32), 64'hDEAD_BEEF);
    check("st_ext32",   64'(ext32),   64'd4);

    alu_src = 1'b0; fwd_sel = 2'b00; rd2_w = 64'd5;
    step();
    check("pre_stall", 64'(srcb32), 64'd5);
    stall = 1'b1; rd2_w = 64'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", 64'(srcb32), 64'd5);
    end
    stall = 1'b0;
    step();
    check("stall_release", 64'(srcb32), 64'd9);

    stall = 1'b1; flush = 1'b1;
    step();
    check("flush_valid", 64'(valid32), 64'd0);
    check("flush_srcb",  64'(srcb32),  64'd0);
    stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();
    check("bubble_valid", 64'(valid64), 64'd0);
    check("bubble_store", store64,      64'd0);

    in_valid = 1'b1; rd2_w = 64'd7;
    step();
    stall = 1'b1; rd2_w = 64'd11;
    step();
    check("hold7", 64'(srcb32), 64'd7);
    reset = 1'b1;
    step();
    check("rst_mid_stall_valid", 64'(valid32), 64'd0);
    check("rst_mid_stall_srcb",  64'(srcb32),  64'd0);
    reset = 1'b0; stall = 1'b0;

    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 49) == 0);
      in_valid = ($urandom_range(0, 4) != 0);
      stall    = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      alu_src  = 1'($urandom);
      fwd_sel  = 2'($urandom);
      ext_mode = 2'($urandom);
      imm      = 16'($urandom);
      rd2_w    = {$urandom, $urandom};
      exmem_w  = {$urandom, $urandom};
      memwb_w  = {$urandom, $urandom};
      step();
    end

    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/srcb_stage.md
# srcb_stage

Parametrised, pipelined successor to the single-cycle ALU source-B select. Sits at the ID/EX boundary of the pipelined core. Each cycle it:
- forwards the register operand from one of three sources;
- extends the instruction immediate in one of three modes;
- selects ALU source B;
- registers the result together with the forwarded store data and a valid bit.

It honours stall (hold) and flush (bubble) from the hazard unit.

## Interface

Parameters:
- DW, 32: datapath width.
- IW, 16: immediate width; DW > IW required.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  decode stage presents a valid instruction.
- stall  input  1  hold all output registers.
- flush  input  1  replace the next registered instruction with a bubble.
- rd2  input  DW  register-file read port 2.
- exmem_result  input  DW  forwarding source from the EX/MEM stage.
- memwb_result  input  DW  forwarding source from the MEM/WB stage.
- fwd_sel  input  2  operand source: 00 rd2, 01 exmem_result, 10 memwb_result, 11 treated as 00.
- imm  input  IW  raw immediate field.
- ext_mode  input  2  immediate extension: 00 sign, 01 zero, 10 upper (imm << (DW-IW), low bits zero), 11 treated as 00.
- alu_src  input  1  source-B select: 0 forwarded register operand, 1 extended immediate.
- out_valid  output  1  registered valid.
- srcb  output  DW  registered ALU source B.
- store_data  output  DW  registered forwarded operand, used for stores regardless of alu_src.
- ext_imm  output  DW  registered extended immediate, used by the branch-target adder.

## Operation

- Combinational front end:
  - op = mux(fwd_sel).
  - ext = extend(imm, ext_mode).
  - b = alu_src ? ext : op.
- Sign mode:
  - ext[DW-1:IW] = {DW-IW{imm[IW-1]}}.
  - ext[IW-1:0] = imm.
- Zero mode: upper bits are 0.
- Upper mode: ext = {imm, {DW-IW{1'b0}}}.
- Register update on each rising clk, in priority order:
  1. reset: out_valid=0, srcb=0, store_data=0, ext_imm=0.
  2. flush: out_valid=0, data registers cleared to 0. Flush beats stall.
  3. stall: all registers hold.
  4. else: out_valid=in_valid, srcb=b, store_data=op, ext_imm=ext. When in_valid=0, the data registers load 0.
- Reserved encodings (fwd_sel=11, ext_mode=11) behave exactly as 00; no error flag.
- During a stall the block does not sample its inputs. Upstream re-presents the instruction, with forwarding re-resolved, when stall drops.

## Timing

- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Throughput is 1 instruction per cycle when not stalled.
- All outputs are 0 from the first edge with reset=1 and remain 0 until the first non-reset edge.
- Reset asserted mid-stall or mid-flush: reset wins at that edge.
- Stall held for k cycles: outputs are constant for k edges, then update on the first edge with stall=0.
- Simultaneous stall=1 and flush=1: the bubble is inserted and stall is ignored for that edge.
- No combinational path from inputs to outputs.

## Structure

- Shared package mips_pkg holds:
  - EXT_SIGN/EXT_ZERO/EXT_UPPER encodings;
  - FWD_RF/FWD_EXMEM/FWD_MEMWB encodings.
- One combinational sub-module, imm_ext (parameters DW, IW; ports imm, ext_mode, ext). It is reused by the branch-target logic.
- Forwarding mux, source-B mux and the output register live in srcb_stage.

## Test plan

- Reset and extension (DW=32, IW=16):
  - reset=1 for 2 cycles: all outputs 0.
  - Then imm=16'h8001, ext_mode=00, alu_src=1, in_valid=1: srcb=32'hFFFF8001 after 1 edge, out_valid=1.
  - Same imm with ext_mode=01: srcb=32'h00008001.
  - Same imm with ext_mode=10: srcb=32'h80010000.
- Forwarding: rd2=1, exmem_result=2, memwb_result=3, alu_src=0.
  - fwd_sel=00/01/10/11: srcb and store_data=1/2/3/1 on successive edges.
- Store path: alu_src=1, imm=16'h0004, fwd_sel=01, exmem_result=32'hDEADBEEF: srcb=4, store_data=32'hDEADBEEF, ext_imm=4.
- Stall: load srcb=5, then stall=1 for 3 cycles while the inputs change to 9: srcb stays 5 for 3 edges and becomes 9 on the edge after stall drops.
- Flush and priority: with a valid instruction loaded, assert stall=1 and flush=1 together: next edge out_valid=0, srcb=0. in_valid=0 with no stall: out_valid=0, data 0.
- Reset mid-stall: stall=1 holding srcb=7, assert reset: outputs 0 at that edge.
- Parameter sweep: repeat the first scenario with DW=64, IW=16: imm=16'h8001 sign mode gives 64'hFFFFFFFFFFFF8001.
